// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen: command front-end for the SR flip-flop stage.
// Two raw, possibly bouncing request lines are synchronised, debounced and
// edge-detected. The result is arbitrated into clean one-cycle s / r pulses
// that are spaced by a hold-off window. s and r are never high together.

// ---------------------------------------------------------------------------
// sr_cmd_debounce: one request channel.
// 2-flop synchroniser, counter debounce and rising-edge detect.
// ---------------------------------------------------------------------------
module sr_cmd_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic rise
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_1;
    logic             x_sync;
    logic             deb;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;

    // Two-flop synchroniser; the raw line is never used before x_sync.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling the
        // pre-edge value, so the chain shifts by exactly one stage per clock.
        if (rst) begin
            sync_1 <= 1'b0;
            x_sync <= 1'b0;
        end else begin
            sync_1 <= raw;
            x_sync <= sync_1;
        end
    end

    // Debounce: deb only follows x_sync after DEB_CYCLES consecutive
    // mismatches; any sample that agrees with deb restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (x_sync == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            deb <= ~deb;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Delayed copy of deb for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_d <= 1'b0;
        end else begin
            deb_d <= deb;
        end
    end

    // Only the 0->1 transition of the debounced value is a request.
    assign rise = deb & ~deb_d;

endmodule

// ---------------------------------------------------------------------------
// sr_cmd_gen: top level.
// ---------------------------------------------------------------------------
module sr_cmd_gen #(
    parameter int DEB_CYCLES = 4,
    parameter int HOLDOFF    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_in,
    input  logic reset_in,
    output logic s,
    output logic r,
    output logic busy
);

    // A zero-length hold-off still needs a one-bit counter to stay legal.
    localparam int HO_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HOLDOFF);

    logic            rise_s;
    logic            rise_r;
    logic            pending_s;
    logic            pending_r;
    logic [HO_W-1:0] holdoff;

    logic            issue_s;
    logic            issue_r;
    logic            pending_s_next;
    logic            pending_r_next;
    logic [HO_W-1:0] holdoff_next;

    sr_cmd_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_set (
        .clk  (clk),
        .rst  (rst),
        .raw  (set_in),
        .rise (rise_s)
    );

    sr_cmd_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb_reset (
        .clk  (clk),
        .rst  (rst),
        .raw  (reset_in),
        .rise (rise_r)
    );

    // Arbitration and hold-off: reset requests win, and any issue drops a
    // simultaneous set request. New edges during hold-off wait in pending.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        issue_s        = 1'b0;
        issue_r        = 1'b0;
        holdoff_next   = '0;

        if (holdoff == '0) begin
            if (pending_r) begin
                issue_r = 1'b1;
            end else if (pending_s) begin
                issue_s = 1'b1;
            end
        end

        if (issue_s || issue_r) begin
            holdoff_next = HO_LOAD;
        end else if (holdoff != '0) begin
            holdoff_next = holdoff - 1'b1;
        end

        // A fresh edge always lands; an edge on an already-pending channel
        // is simply absorbed by the OR.
        pending_r_next = rise_r | (pending_r & ~issue_r);
        pending_s_next = rise_s | (pending_s & ~(issue_s | issue_r));
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_s <= 1'b0;
            pending_r <= 1'b0;
            holdoff   <= '0;
            s         <= 1'b0;
            r         <= 1'b0;
            busy      <= 1'b0;
        end else begin
            pending_s <= pending_s_next;
            pending_r <= pending_r_next;
            holdoff   <= holdoff_next;
            s         <= issue_s;
            r         <= issue_r;
            busy      <= (holdoff_next != '0);
        end
    end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen: directed bench for sr_cmd_gen (DEB_CYCLES=4, HOLDOFF=2).
// Each case drives 40 edges from bit vectors (bit k = input value sampled at
// edge k) and records s / r / busy just after every edge into matching
// vectors, which are compared with hand-computed expectations.
module tb_sr_cmd_gen;

    logic clk = 1'b0;
    logic rst;
    logic set_in;
    logic reset_in;
    logic s;
    logic r;
    logic busy;

    int checks = 0;
    int errors = 0;

    logic [39:0] s_tr;
    logic [39:0] r_tr;
    logic [39:0] busy_tr;

    sr_cmd_gen #(
        .DEB_CYCLES (4),
        .HOLDOFF    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .set_in   (set_in),
        .reset_in (reset_in),
        .s        (s),
        .r        (r),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        set_in   = 1'b0;
        reset_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_case(input logic [39:0] sv, input logic [39:0] rv, input logic [39:0] xv);
        apply_reset();
        for (int k = 0; k < 40; k++) begin
            set_in   = sv[k];
            reset_in = rv[k];
            rst      = xv[k];
            @(posedge clk);
            #1;
            s_tr[k]    = s;
            r_tr[k]    = r;
            busy_tr[k] = busy;
        end
        set_in   = 1'b0;
        reset_in = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic check_case(input string name, input logic [39:0] es,
                              input logic [39:0] er, input logic [39:0] eb);
        check({name, "_s"},    s_tr,        es);
        check({name, "_r"},    r_tr,        er);
        check({name, "_busy"}, busy_tr,     eb);
        check({name, "_excl"}, s_tr & r_tr, 40'h0);
    endtask

    initial begin
        apply_reset();
        check("rst_s",    {39'h0, s},    40'h0);
        check("rst_r",    {39'h0, r},    40'h0);
        check("rst_busy", {39'h0, busy}, 40'h0);

        // 1: set held 20 cycles -> s after edge 7, busy after edges 7 and 8.
        run_case(40'h00000FFFFF, 40'h0, 40'h0);
        check_case("t1_hold", 40'h80, 40'h0, 40'h180);

        // 2: toggle 1/0 on edges 0..5, held high from E=6 -> s after edge 13.
        run_case(40'h007FFFFFD5, 40'h0, 40'h0);
        check_case("t2_bounce", 40'h2000, 40'h0, 40'h6000);

        // 3: both rise together -> r after edge 7, set dropped.
        run_case(40'h00000FFFFF, 40'h00000FFFFF, 40'h0);
        check_case("t3_both", 40'h0, 40'h80, 40'h180);

        // 4: set at 0, reset at 1 -> s after 7, r held off until edge 10.
        run_case(40'h00000FFFFF, 40'h00000FFFFE, 40'h0);
        check_case("t4_holdoff", 40'h80, 40'h400, 40'hD80);

        // 5: rst at edge 4 discards progress -> s after edge 12.
        run_case(40'h003FFFFFFF, 40'h0, 40'h10);
        check_case("t5_midrst", 40'h1000, 40'h0, 40'h3000);

        // 6: set high 10 cycles then low -> one s on the rise, none on the fall.
        run_case(40'h00000003FF, 40'h0, 40'h0);
        check_case("t6_fall", 40'h80, 40'h0, 40'h180);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
